// File: rtl/conv_frame_buffer_if.sv
// Stream bundle for conv_frame_buffer: pixel load, window groups, readout.
// The buffer side uses the slave modport, the driving side the master.
interface conv_frame_buffer_if #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int KERNEL_WIDTH = 3
);
  logic                              i_start;
  logic                              i_wr_valid;
  logic [PIXEL_WIDTH-1:0]            i_wr_data;
  logic                              o_wr_ready;
  logic                              o_conv_valid;
  logic [KERNEL_WIDTH*PIXEL_WIDTH-1:0] o_conv_data;
  logic                              i_conv_ready;
  logic                              o_rd_valid;
  logic [PIXEL_WIDTH-1:0]            o_rd_data;
  logic                              i_rd_ready;
  logic                              o_frame_ready;
  logic                              o_busy;

  modport master (
    output i_start, i_wr_valid, i_wr_data,
    output i_conv_ready, i_rd_ready,
    input  o_wr_ready, o_conv_valid, o_conv_data,
    input  o_rd_valid, o_rd_data,
    input  o_frame_ready, o_busy
  );

  modport slave (
    input  i_start, i_wr_valid, i_wr_data,
    input  i_conv_ready, i_rd_ready,
    output o_wr_ready, o_conv_valid, o_conv_data,
    output o_rd_valid, o_rd_data,
    output o_frame_ready, o_busy
  );
endinterface

// File: rtl/conv_frame_buffer.sv
// Frame buffer + column-major window sequencer for the convolver.
// Define CONV_FB_ZERO_PAD_EN for horizontal zero padding of the windows.
module conv_frame_buffer #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int KERNEL_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  conv_frame_buffer_if.slave bus
);
  localparam int PW  = PIXEL_WIDTH;
  localparam int IW  = IMAGE_WIDTH;
  localparam int IH  = IMAGE_HEIGHT;
  localparam int K   = KERNEL_WIDTH;
  localparam int RES = IW * IH;
`ifdef CONV_FB_ZERO_PAD_EN
  localparam int P    = (K - 1) / 2;
  localparam int NCOL = IW;
`else
  localparam int P    = 0;
  localparam int NCOL = IW - K + 1;
`endif
  localparam int AW = (RES > 1) ? $clog2(RES) : 1;
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int RW = (IH > 1) ? $clog2(IH) : 1;
  localparam int JW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PROC, READ} state_t;
  state_t state;

  logic [AW-1:0] addr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [JW-1:0] kj;
  logic          fetch;
  logic          pend;
  logic          pend_pad;
  logic [JW-1:0] pend_j;

  logic [PW-1:0] mem [RES];
  logic [PW-1:0] rd_q;

  int            pos;
  logic          in_range;
  logic [AW-1:0] win_addr;
  logic [AW-1:0] ram_addr;
  logic          we;
  logic          re;

  always_comb begin
    pos      = int'(col) + int'(kj) - P;
    in_range = (pos >= 0) && (pos < IW);
    win_addr = AW'(int'(row) * IW + pos);
    we       = (state == LOAD) && bus.i_wr_valid
             && bus.o_wr_ready;
    re       = fetch && ((state == READ)
             || ((state == PROC) && in_range));
    ram_addr = (state == PROC) ? win_addr : addr;
  end

  always_ff @(posedge clk) begin
    if (we) mem[ram_addr] <= bus.i_wr_data;
    if (re) rd_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      addr              <= '0;
      col               <= '0;
      row               <= '0;
      kj                <= '0;
      fetch             <= 1'b0;
      pend              <= 1'b0;
      pend_pad          <= 1'b0;
      pend_j            <= '0;
      bus.o_wr_ready    <= 1'b0;
      bus.o_conv_valid  <= 1'b0;
      bus.o_conv_data   <= '0;
      bus.o_rd_valid    <= 1'b0;
      bus.o_rd_data     <= '0;
      bus.o_frame_ready <= 1'b0;
      bus.o_busy        <= 1'b0;
    end else begin
      // Read data lands in rd_q one cycle after the issue cycle.
      pend     <= fetch;
      pend_j   <= kj;
      pend_pad <= (state == PROC) && !in_range;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            state          <= LOAD;
            addr           <= '0;
            bus.o_wr_ready <= 1'b1;
            bus.o_busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (we) begin
            if (addr == AW'(RES - 1)) begin
              state          <= PROC;
              addr           <= '0;
              col            <= '0;
              row            <= '0;
              kj             <= '0;
              fetch          <= 1'b1;
              bus.o_wr_ready <= 1'b0;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        PROC: begin
          if (fetch) begin
            if (kj == JW'(K - 1)) begin
              kj    <= '0;
              fetch <= 1'b0;
            end else begin
              kj <= kj + 1'b1;
            end
          end
          if (pend) begin
            bus.o_conv_data[int'(pend_j)*PW +: PW]
              <= pend_pad ? '0 : rd_q;
            if (pend_j == JW'(K - 1))
              bus.o_conv_valid <= 1'b1;
          end
          if (bus.o_conv_valid && bus.i_conv_ready) begin
            bus.o_conv_valid <= 1'b0;
            fetch            <= 1'b1;
            if (row == RW'(IH - 1)) begin
              row <= '0;
              if (col == CW'(NCOL - 1)) begin
                state             <= READ;
                addr              <= '0;
                bus.o_frame_ready <= 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        READ: begin
          if (fetch) fetch <= 1'b0;
          if (pend) begin
            bus.o_rd_data  <= rd_q;
            bus.o_rd_valid <= 1'b1;
          end
          if (bus.o_rd_valid && bus.i_rd_ready) begin
            bus.o_rd_valid <= 1'b0;
            if (addr == AW'(RES - 1)) begin
              state             <= IDLE;
              bus.o_frame_ready <= 1'b0;
              bus.o_busy        <= 1'b0;
            end else begin
              addr  <= addr + 1'b1;
              fetch <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_frame_buffer.sv
// Directed bench for conv_frame_buffer on a 4x4 frame with K=3.
// Group expectations follow CONV_FB_ZERO_PAD_EN when defined.
module tb_conv_frame_buffer;
  localparam int PW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int K  = 3;
`ifdef CONV_FB_ZERO_PAD_EN
  localparam int P    = 1;
  localparam int NCOL = 4;
`else
  localparam int P    = 0;
  localparam int NCOL = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  conv_frame_buffer_if #(
    .PIXEL_WIDTH(PW), .KERNEL_WIDTH(K)
  ) bus ();

  conv_frame_buffer #(
    .PIXEL_WIDTH(PW), .IMAGE_WIDTH(IW),
    .IMAGE_HEIGHT(IH), .KERNEL_WIDTH(K)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] grp(input int base,
                                      input int c,
                                      input int r);
    logic [31:0] g;
    int p;
    g = '0;
    for (int j = 0; j < K; j++) begin
      p = c + j - P;
      if (p >= 0 && p < IW) g[j*PW +: PW] = 8'(base + r*IW + p);
    end
    return g;
  endfunction

  task automatic wait_valid;
    int t;
    t = 0;
    while (!bus.o_conv_valid && t < 40) begin
      tick;
      t++;
    end
  endtask

  task automatic get_group(input string tag,
                           input logic [31:0] exp);
    wait_valid;
    chk({tag, "_valid"}, bus.o_conv_valid, 1);
    chk(tag, bus.o_conv_data, exp);
    bus.i_conv_ready = 1'b1;
    tick;
    bus.i_conv_ready = 1'b0;
  endtask

  task automatic load(input int base);
    bus.i_start = 1'b1;
    tick;
    bus.i_start = 1'b0;
    chk("load_wr_ready", bus.o_wr_ready, 1);
    chk("load_busy", bus.o_busy, 1);
    bus.i_wr_valid = 1'b1;
    for (int i = 0; i < IW*IH; i++) begin
      bus.i_wr_data = 8'(base + i);
      bus.i_start = (i == 5);
      tick;
    end
    bus.i_wr_valid = 1'b0;
    bus.i_start = 1'b0;
    chk("proc_wr_ready", bus.o_wr_ready, 0);
    chk("proc_busy", bus.o_busy, 1);
  endtask

  initial begin
    int got;
    int t;
    logic ph;
    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_data = '0;
    bus.i_conv_ready = 1'b0;
    bus.i_rd_ready = 1'b0;
    repeat (3) tick;
    chk("rst_wr_ready", bus.o_wr_ready, 0);
    chk("rst_conv_valid", bus.o_conv_valid, 0);
    chk("rst_conv_data", bus.o_conv_data, 0);
    chk("rst_rd_valid", bus.o_rd_valid, 0);
    chk("rst_rd_data", bus.o_rd_data, 0);
    chk("rst_frame_ready", bus.o_frame_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    reset = 1'b0;

    bus.i_wr_valid = 1'b1;
    bus.i_wr_data = 8'hEE;
    repeat (3) tick;
    bus.i_wr_valid = 1'b0;
    chk("idle_busy", bus.o_busy, 0);
    chk("idle_wr_ready", bus.o_wr_ready, 0);

    load(0);
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < IH; r++) begin
        if (c == 0 && r == 1) begin
          wait_valid;
          for (int h = 0; h < 10; h++) begin
            tick;
            chk("hold_valid", bus.o_conv_valid, 1);
            chk("hold_data", bus.o_conv_data, grp(0, 0, 1));
          end
          bus.i_conv_ready = 1'b1;
          tick;
          bus.i_conv_ready = 1'b0;
        end else begin
          get_group($sformatf("g_c%0d_r%0d", c, r), grp(0, c, r));
        end
      end
    end
    chk("frame_ready", bus.o_frame_ready, 1);
    chk("conv_valid_done", bus.o_conv_valid, 0);

    got = 0;
    t = 0;
    ph = 1'b0;
    while (got < IW*IH && t < 300) begin
      ph = ~ph;
      bus.i_rd_ready = ph;
      if (bus.o_rd_valid && ph) begin
        chk($sformatf("rd%0d", got), bus.o_rd_data, 32'(got));
        got++;
      end
      tick;
      t++;
    end
    bus.i_rd_ready = 1'b0;
    chk("rd_count", got, IW*IH);
    chk("rd_done_busy", bus.o_busy, 0);
    chk("rd_done_frame_ready", bus.o_frame_ready, 0);
    chk("rd_done_valid", bus.o_rd_valid, 0);

    load(200);
    for (int r = 0; r < 3; r++)
      get_group($sformatf("pre_rst_r%0d", r), grp(200, 0, r));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_conv_valid", bus.o_conv_valid, 0);
    chk("mid_rst_conv_data", bus.o_conv_data, 0);
    chk("mid_rst_wr_ready", bus.o_wr_ready, 0);

    load(100);
    get_group("reload_g0", grp(100, 0, 0));
    get_group("reload_g1", grp(100, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
